// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM state
// encoding and the one-hot operand-load select codes.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    SQR    = 3'd3,
    NEXT   = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [2:0] SEL_EXP  = 3'b001;
  localparam logic [2:0] SEL_MOD  = 3'b010;
  localparam logic [2:0] SEL_BASE = 3'b100;

endpackage

// File: rtl/mod_exp_engine_mod_mult.sv
// Blakley interleaved modular multiplier: P = A*B mod N, one bit of A per
// cycle MSB-first. A go cycle loads the operands; ack marks the last step.
module mod_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_busy,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = WIDTH + 2;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [AW-1:0]    w_n_ext;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_step;

  function automatic logic [AW-1:0] sub_if_ge(input logic [AW-1:0] v,
                                              input logic [AW-1:0] n);
    logic [AW-1:0] res;
    if (v >= n) begin
      res = v - n;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // 2P + B stays below 3N, so two conditional subtractions fully reduce it.
  assign w_n_ext = {2'b00, r_n};
  assign w_sum   = {r_acc[AW-2:0], 1'b0} + (r_a[WIDTH-1] ? {2'b00, r_b} : {AW{1'b0}});
  assign w_step  = sub_if_ge(sub_if_ge(w_sum, w_n_ext), w_n_ext);

  assign o_busy = r_busy;
  assign o_ack  = r_busy & (r_cnt == {CW{1'b0}});
  assign o_p    = w_step[WIDTH-1:0];

  // Operand capture on go, then one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_n    <= {WIDTH{1'b0}};
      r_acc  <= {AW{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_acc <= w_step;
      r_a   <= {r_a[WIDTH-2:0], 1'b0};
      if (r_cnt == {CW{1'b0}}) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (i_go) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_n    <= i_n;
      r_acc  <= {AW{1'b0}};
      r_cnt  <= CW'(WIDTH - 1);
      r_busy <= 1'b1;
    end else begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left square-and-multiply modular exponentiation
// engine built around a single Blakley modular multiplier.
module mod_exp_engine #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] load_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  import mod_exp_pkg::*;

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [IW-1:0]    r_idx;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [WIDTH-1:0] r_result;

  logic             w_go;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_n;
  logic             w_mm_busy;
  logic             w_mm_ack;
  logic [WIDTH-1:0] w_mm_p;
  logic             w_mod_zero;

  assign w_mod_zero = (r_mod == {WIDTH{1'b0}});

  assign busy   = r_busy;
  assign done   = r_done;
  assign error  = r_error;
  assign result = r_result;

  mod_mult #(.WIDTH(WIDTH)) u_mod_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_go   (w_go),
    .i_a    (w_a),
    .i_b    (w_b),
    .i_n    (w_n),
    .o_busy (w_mm_busy),
    .o_ack  (w_mm_ack),
    .o_p    (w_mm_p)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and multiplier launch. The reduce multiply launches in the
  // start cycle and each later MUL launches from NEXT, so every multiply
  // takes WIDTH+1 cycles with no idle gaps between them.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_a         = r_r;
    w_b         = r_b;
    w_n         = r_n;
    case (r_state)
      IDLE: begin
        if (start && w_mod_zero) begin
          w_state_nxt = FIN;
        end else if (start) begin
          w_state_nxt = REDUCE;
          w_go        = 1'b1;
          w_a         = r_base;
          w_b         = ONE;
          w_n         = r_mod;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REDUCE: begin
        if (w_mm_ack) begin
          w_state_nxt = MUL;
        end else begin
          w_state_nxt = REDUCE;
        end
      end
      MUL: begin
        w_go = ~w_mm_busy;
        if (w_mm_ack) begin
          w_state_nxt = SQR;
        end else begin
          w_state_nxt = MUL;
        end
      end
      SQR: begin
        w_go = ~w_mm_busy;
        w_a  = r_b;
        if (w_mm_ack) begin
          w_state_nxt = NEXT;
        end else begin
          w_state_nxt = SQR;
        end
      end
      NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = MUL;
          w_go        = 1'b1;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers; writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp  <= {WIDTH{1'b0}};
      r_mod  <= {WIDTH{1'b0}};
      r_base <= {WIDTH{1'b0}};
    end else if (r_state == IDLE) begin
      if ((load_sel & SEL_EXP) != 3'b000) begin
        r_exp <= din;
      end else begin
        r_exp <= r_exp;
      end
      if ((load_sel & SEL_MOD) != 3'b000) begin
        r_mod <= din;
      end else begin
        r_mod <= r_mod;
      end
      if ((load_sel & SEL_BASE) != 3'b000) begin
        r_base <= din;
      end else begin
        r_base <= r_base;
      end
    end else begin
      r_exp  <= r_exp;
      r_mod  <= r_mod;
      r_base <= r_base;
    end
  end

  // Working datapath and registered status outputs. Working copies are taken
  // from the pre-load operand values when a load coincides with start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= {WIDTH{1'b0}};
      r_e      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      r_idx    <= {IW{1'b0}};
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= {WIDTH{1'b0}};
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n     <= r_mod;
            r_e     <= r_exp;
            r_r     <= ONE;
            r_idx   <= {IW{1'b0}};
            r_zero  <= w_mod_zero;
            r_error <= 1'b0;
          end
        end
        REDUCE: begin
          if (w_mm_ack) begin
            r_b <= w_mm_p;
          end
        end
        MUL: begin
          if (w_mm_ack && r_e[0]) begin
            r_r <= w_mm_p;
          end
        end
        SQR: begin
          if (w_mm_ack) begin
            r_b <= w_mm_p;
          end
        end
        NEXT: begin
          r_e   <= {1'b0, r_e[WIDTH-1:1]};
          r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
        end
        FIN: begin
          // r only stays unreduced when N=1 (initial 1 never multiplied).
          if (r_zero) begin
            r_result <= {WIDTH{1'b0}};
          end else if (r_r >= r_n) begin
            r_result <= r_r - r_n;
          end else begin
            r_result <= r_r;
          end
          r_error <= r_zero;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits of base, exponent, modulus and result.
REQ-002 SHALL have parameter SEL_W, default 3, giving the width of the operand-load select; the value is fixed at 3.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, WIDTH bits: operand load data.
REQ-006 SHALL have port load_sel, input, SEL_W bits: one-hot operand select; 001 exponent, 010 modulus, 100 base.
REQ-007 SHALL have port start, input, 1 bit: begin exponentiation.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port error, output, 1 bit: modulus was zero on the last start.
REQ-011 SHALL have port result, output, WIDTH bits: base^exponent mod modulus.

Function
REQ-012 SHALL, while busy=0, load din on each clock edge into every register whose load_sel bit is set; more than one set bit loads all the selected registers.
REQ-013 SHALL ignore load_sel and start while busy=1.
REQ-014 SHALL accept start only when busy=0, and SHALL treat the cycle start is sampled as cycle 0.
REQ-015 SHALL, if start coincides with a load, use the operand values from before the load.
REQ-016 SHALL use states IDLE, REDUCE, MUL, SQR, NEXT and FIN.
REQ-017 SHALL transition IDLE->REDUCE on an accepted start; REDUCE->MUL; MUL->SQR; SQR->NEXT; NEXT->MUL while exponent bits remain; NEXT->FIN after bit WIDTH-1; FIN->IDLE.
REQ-018 SHALL, in REDUCE, compute b = base mod modulus as mod_mult(base, 1).
REQ-019 SHALL scan the exponent right-to-left from LSB to MSB over all WIDTH bits.
REQ-020 SHALL, in MUL, compute t = r*b mod N and commit r=t only when the current exponent bit is 1; the multiply SHALL be performed regardless of the bit (constant time).
REQ-021 SHALL, in SQR, compute b = b*b mod N.
REQ-022 SHALL initialise r to 1 at start.
REQ-023 SHALL have each mod_mult operation occupy exactly WIDTH+1 cycles.
REQ-024 SHALL give total latency from start to done of exactly (2*WIDTH+1)*(WIDTH+1)+1 cycles, independent of operand values (562 cycles at WIDTH=16).
REQ-025 SHALL update result in the FIN cycle, pulse done for that cycle only, drop busy in the same cycle, and hold result until the next accepted start.
REQ-026 SHALL, when modulus=0 at start, skip computation, set result=0 and error=1, and pulse done at cycle 1.
REQ-027 SHALL clear error on the next accepted start.
REQ-028 SHALL, when modulus=1, produce result=0 with normal latency.
REQ-029 SHALL, when exponent=0 and modulus>1, produce result=1.
REQ-030 SHALL accept base >= modulus, reduced in REDUCE.
REQ-031 SHALL hold the mod_mult internal accumulator in WIDTH+2 bits, since 2P+B < 3N.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear busy, done, error, result and the operand registers, and force state to IDLE, including when reset asserts mid-operation.
REQ-033 SHALL, after rst_n deasserts, require a fresh operand load and start before producing any result.

Structure
REQ-034 SHALL place the state encoding and the load_sel codes (SEL_EXP, SEL_MOD, SEL_BASE) in shared package mod_exp_pkg.
REQ-035 SHALL implement the single sub-module mod_mult, a Blakley interleaved multiplier parameterised by WIDTH.
REQ-036 SHALL give mod_mult a go/ack handshake, process one multiplier bit per cycle MSB-first, apply two conditional subtractions of N per step, and ack in its (WIDTH+1)th cycle.

Verification
REQ-037 SHALL cover: base=11, exp=5, mod=223 -> result=45, done at cycle 562, error=0.
REQ-038 SHALL cover: RSA encrypt base=65, exp=17, mod=3233 -> 2790; then decrypt base=2790, exp=2753, mod=3233 -> 65.
REQ-039 SHALL cover: base=300, exp=1, mod=223 -> 77; and exp=0, mod=223 -> 1.
REQ-040 SHALL cover: mod=0 with start -> done and error at cycle 1, result=0; the next valid start clears error.
REQ-041 SHALL cover: rst_n low at cycle 200 of a run -> busy, done and result equal 0 immediately; a start during busy and a load during busy are both ignored, so the result is unchanged versus an undisturbed run.
